// File: rtl/clct_lut_fetch.sv
// Request/response front end for the dual-port pattern lookup ROM: queues CLCT candidates, issues up to two
// lookups per cycle, realigns ROM data with side info and drains results in order. Optional macro: CLCT_LUT_STATS_EN.
module clct_lut_fetch #(
  parameter int MXPIDB = 4,
  parameter int MXCCB  = 8,
  parameter int MXADRB = 12,
  parameter int MXDATB = 9,
  parameter int MXKHSB = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [MXPIDB-1:0] in_pid_i,
  input  logic [MXCCB-1:0]  in_ccode_i,
  input  logic [MXKHSB-1:0] in_khs_i,
  output logic [MXADRB-1:0] rom_adr0_o,
  output logic [MXADRB-1:0] rom_adr1_o,
  input  logic [MXDATB-1:0] rom_rd0_i,
  input  logic [MXDATB-1:0] rom_rd1_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MXPIDB-1:0] out_pid_o,
  output logic [MXKHSB-1:0] out_khs_o,
  output logic [MXDATB-1:0] out_lut_o
`ifdef CLCT_LUT_STATS_EN
  ,
  output logic [15:0]       lookup_count_o,
  output logic [15:0]       stall_count_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [MXPIDB-1:0] fifo_pid_q [DEPTH];
  logic [MXCCB-1:0]  fifo_cc_q  [DEPTH];
  logic [MXKHSB-1:0] fifo_khs_q [DEPTH];
  logic [PW-1:0]     fifo_wr_q, fifo_rd_q, fifo_rd1;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic [MXPIDB-1:0] ob_pid_q [DEPTH];
  logic [MXKHSB-1:0] ob_khs_q [DEPTH];
  logic [MXDATB-1:0] ob_lut_q [DEPTH];
  logic [PW-1:0]     ob_wr_q, ob_rd_q, ob_wr1;
  logic [CW-1:0]     ob_cnt_q, ob_cnt_d;

  logic [CW-1:0]     credit_q, credit_d;
  logic              v0_q, v1_q;
  logic [MXPIDB-1:0] pid0_q, pid1_q;
  logic [MXKHSB-1:0] khs0_q, khs1_q;

  logic              push, pop_out;
  logic [1:0]        n_issue;

  always_comb begin
    in_ready_o = reset_n_i && (fifo_cnt_q != CW'(DEPTH));
    push       = in_valid_i && in_ready_o;
    out_valid_o = (ob_cnt_q != '0);
    pop_out    = out_valid_o && out_ready_i;
    fifo_rd1   = fifo_rd_q + PW'(1);
    ob_wr1     = ob_wr_q + PW'(1);
    n_issue    = 2'd0;
    if (reset_n_i) begin
      if (fifo_cnt_q >= CW'(2) && credit_q >= CW'(2)) n_issue = 2'd2;
      else if (fifo_cnt_q != '0 && credit_q != '0)    n_issue = 2'd1;
    end
    rom_adr0_o = (n_issue != 2'd0) ? {fifo_pid_q[fifo_rd_q], fifo_cc_q[fifo_rd_q]} : '0;
    rom_adr1_o = (n_issue == 2'd2) ? {fifo_pid_q[fifo_rd1], fifo_cc_q[fifo_rd1]} : '0;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(n_issue);
    credit_d   = credit_q - CW'(n_issue) + CW'(pop_out);
    ob_cnt_d   = ob_cnt_q + CW'(v0_q) + CW'(v1_q) - CW'(pop_out);
    out_pid_o  = out_valid_o ? ob_pid_q[ob_rd_q] : '0;
    out_khs_o  = out_valid_o ? ob_khs_q[ob_rd_q] : '0;
    out_lut_o  = out_valid_o ? ob_lut_q[ob_rd_q] : '0;
  end

  // Payload storage carries no reset; occupancy counts alone decide what is live.
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_pid_q[fifo_wr_q] <= in_pid_i;
      fifo_cc_q[fifo_wr_q]  <= in_ccode_i;
      fifo_khs_q[fifo_wr_q] <= in_khs_i;
    end
    if (v0_q) begin
      ob_pid_q[ob_wr_q] <= pid0_q;
      ob_khs_q[ob_wr_q] <= khs0_q;
      ob_lut_q[ob_wr_q] <= rom_rd0_i;
    end
    if (v1_q) begin
      ob_pid_q[ob_wr1] <= pid1_q;
      ob_khs_q[ob_wr1] <= khs1_q;
      ob_lut_q[ob_wr1] <= rom_rd1_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      ob_wr_q    <= '0;
      ob_rd_q    <= '0;
      ob_cnt_q   <= '0;
      credit_q   <= CW'(DEPTH);
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      pid0_q     <= '0;
      pid1_q     <= '0;
      khs0_q     <= '0;
      khs1_q     <= '0;
    end else begin
      if (push) fifo_wr_q <= fifo_wr_q + PW'(1);
      fifo_rd_q  <= fifo_rd_q + PW'(n_issue);
      fifo_cnt_q <= fifo_cnt_d;
      credit_q   <= credit_d;
      ob_wr_q    <= ob_wr_q + PW'(v0_q) + PW'(v1_q);
      if (pop_out) ob_rd_q <= ob_rd_q + PW'(1);
      ob_cnt_q   <= ob_cnt_d;
      // Side info rides alongside the ROM's one-cycle read register.
      v0_q       <= (n_issue != 2'd0);
      v1_q       <= (n_issue == 2'd2);
      pid0_q     <= fifo_pid_q[fifo_rd_q];
      khs0_q     <= fifo_khs_q[fifo_rd_q];
      pid1_q     <= fifo_pid_q[fifo_rd1];
      khs1_q     <= fifo_khs_q[fifo_rd1];
    end
  end

`ifdef CLCT_LUT_STATS_EN
  logic [15:0] lookup_q, lookup_d, stall_q, stall_d;
  logic [16:0] lookup_sum;

  always_comb begin
    lookup_sum = {1'b0, lookup_q} + 17'(n_issue);
    lookup_d   = lookup_sum[16] ? 16'hFFFF : lookup_sum[15:0];
    stall_d    = stall_q;
    if (out_valid_o && !out_ready_i && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      lookup_q <= '0;
      stall_q  <= '0;
    end else begin
      lookup_q <= lookup_d;
      stall_q  <= stall_d;
    end
  end

  assign lookup_count_o = lookup_q;
  assign stall_count_o  = stall_q;
`endif

endmodule

// File: tb/tb_clct_lut_fetch.sv
// Randomized bench for clct_lut_fetch against a queue-based reference of expected results; ROM modelled as a hash.
module tb_clct_lut_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_pid, out_pid;
  logic [7:0]  in_ccode, in_khs, out_khs;
  logic [11:0] rom_adr0, rom_adr1;
  logic [8:0]  rom_rd0, rom_rd1, out_lut;
`ifdef CLCT_LUT_STATS_EN
  logic [15:0] lookup_count, stall_count;
`endif

  int checks = 0;
  int failures = 0;
  int stall_obs = 0;

  typedef struct packed {
    logic [3:0] pid;
    logic [7:0] khs;
    logic [8:0] lut;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  clct_lut_fetch #(.DEPTH(DEPTH)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pid_i(in_pid), .in_ccode_i(in_ccode), .in_khs_i(in_khs),
    .rom_adr0_o(rom_adr0), .rom_adr1_o(rom_adr1),
    .rom_rd0_i(rom_rd0), .rom_rd1_i(rom_rd1),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pid_o(out_pid), .out_khs_o(out_khs), .out_lut_o(out_lut)
`ifdef CLCT_LUT_STATS_EN
    , .lookup_count_o(lookup_count), .stall_count_o(stall_count)
`endif
  );

  function automatic logic [8:0] rom_f(input logic [11:0] a);
    logic [31:0] x;
    x = ({20'd0, a} * 32'd37) ^ ({20'd0, a} >> 3) ^ 32'h0A5;
    return x[8:0];
  endfunction

  always_ff @(posedge clk) begin
    rom_rd0 <= rom_f(rom_adr0);
    rom_rd1 <= rom_f(rom_adr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, update the reference, then return just after the rising edge.
  task automatic tick();
    res_t r;
    @(negedge clk);
    if (rst_n) begin
      if (out_valid) begin
        chk("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("out_pid", {28'd0, out_pid}, {28'd0, exp_q[0].pid});
          chk("out_khs", {24'd0, out_khs}, {24'd0, exp_q[0].khs});
          chk("out_lut", {23'd0, out_lut}, {23'd0, exp_q[0].lut});
          if (out_ready) begin
            $display("pop pid=%0h khs=%0d lut=%0h", out_pid, out_khs, out_lut);
            void'(exp_q.pop_front());
          end
        end
        if (!out_ready) stall_obs++;
      end
      if (in_valid && in_ready) begin
        r.pid = in_pid;
        r.khs = in_khs;
        r.lut = rom_f({in_pid, in_ccode});
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic single_push(input logic [3:0] p, input logic [7:0] c, input logic [7:0] k);
    in_valid = 1'b1; in_pid = p; in_ccode = c; in_khs = k; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_adr0", {20'd0, rom_adr0}, {20'd0, p, c});
    chk("t1_adr1", {20'd0, rom_adr1}, 32'd0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t2_adr0", {20'd0, rom_adr0}, 32'd0);
    chk("t2_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out_lut", {23'd0, out_lut}, {23'd0, rom_f({p, c})});
    chk("t3_out_khs", {24'd0, out_khs}, {24'd0, k});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pid = '0; in_ccode = '0; in_khs = '0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pid", {28'd0, out_pid}, 32'd0);
    chk("rst_out_khs", {24'd0, out_khs}, 32'd0);
    chk("rst_out_lut", {23'd0, out_lut}, 32'd0);
    chk("rst_adr0", {20'd0, rom_adr0}, 32'd0);
    chk("rst_adr1", {20'd0, rom_adr1}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    single_push(4'h3, 8'h5A, 8'd17);

    // Back-to-back burst with a free-running consumer.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pid = 4'($urandom); in_ccode = 8'($urandom); in_khs = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("burst_accepted", exp_q.size() <= 32'd8 ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("burst_drained", exp_q.size(), 32'd0);

    // Stalled consumer: 2*DEPTH candidates accepted, then push blocked while a FIFO entry drains.
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_pid = 4'($urandom); in_ccode = 8'($urandom); in_khs = 8'($urandom);
      tick();
    end
    chk("full_accepted", exp_q.size(), 2 * DEPTH);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    chk("full_pop_in_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_pop_in_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_release_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("full_drained", exp_q.size(), 32'd0);

    // Mid-operation reset with lookups in flight and results buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pid = 4'($urandom); in_ccode = 8'($urandom); in_khs = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_adr0", {20'd0, rom_adr0}, 32'd0);
    chk("midrst_adr1", {20'd0, rom_adr1}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    single_push(4'hC, 8'h21, 8'd200);

    // Randomized traffic with randomized backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pid = 4'($urandom); in_ccode = 8'($urandom); in_khs = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("random_drained", exp_q.size(), 32'd0);
    chk("random_idle_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef CLCT_LUT_STATS_EN
    do_reset();
    stall_obs = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pid = 4'($urandom); in_ccode = 8'($urandom); in_khs = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && stall_obs < 3; i++) tick();
    chk("stats_stall_seen", stall_obs, 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("stats_lookup", {16'd0, lookup_count}, 32'd5);
    chk("stats_stall", {16'd0, stall_count}, 32'd3);
    single_push(4'h1, 8'h02, 8'd3);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pid = 4'h7; in_ccode = 8'h11; in_khs = 8'd9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 65545; i++) tick();
    chk("stats_stall_sat", {16'd0, stall_count}, 32'h0000FFFF);
    chk("stats_lookup_after", {16'd0, lookup_count}, 32'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
